arch_map_table_n: RTL and testbench
===================================

ARCH_MAP_TABLE_N -- requirements
Module: arch_map_table_n

Interface
REQ-001 SHALL have parameter COMMIT_WIDTH, default 4, number of commit slots (1-8); slot 0 oldest.
REQ-002 SHALL have parameter NUM_LOG_REGS, default 32, logical register count (power of two); LOG_W = log2(NUM_LOG_REGS).
REQ-003 SHALL have parameter PHY_W, default 7, physical tag width; 2^PHY_W >= NUM_LOG_REGS.
REQ-004 SHALL have parameter RECOVER_WIDTH, default 4, entries per recovery beat; divides NUM_LOG_REGS.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-low.
REQ-006 SHALL have ports: commit_valid_i  in  COMMIT_WIDTH  per-slot commit with destination; commit_log_i  in  COMMIT_WIDTH*LOG_W  logical dest; commit_phy_i  in  COMMIT_WIDTH*PHY_W  new physical tag; commit_ready_o  out  1  commits accepted this cycle.
REQ-007 SHALL have ports: release_valid_o  out  COMMIT_WIDTH  per-slot release; release_phy_o  out  COMMIT_WIDTH*PHY_W  tag returned to free list.
REQ-008 SHALL have ports: recover_req_i  in  1  start recovery walk; recover_valid_o  out  1; recover_ready_i  in  1  RMT accepts beat; recover_log_o  out  RECOVER_WIDTH*LOG_W; recover_phy_o  out  RECOVER_WIDTH*PHY_W; recover_done_o  out  1  one-cycle completion pulse.

Function
REQ-009 SHALL hold NUM_LOG_REGS x PHY_W mapping entries in flops with COMMIT_WIDTH write ports.
REQ-010 SHALL accept slot k when commit_valid_i[k] & commit_ready_o; release_valid_o[k] equals that term, combinationally, same cycle.
REQ-011 SHALL write slot k to table[log_k] on the clock edge only if no younger accepted slot j>k has log_j == log_k (youngest wins).
REQ-012 SHALL drive release_phy_o[k] = commit_phy_i[k] for a shadowed slot, else table[log_k] as held before the edge.
REQ-013 SHALL implement FSM IDLE, RECOVER, DONE; commit_ready_o = 1 only in IDLE with reset deasserted.
REQ-014 SHALL, in IDLE with recover_req_i = 1, accept that cycle's commits, then enter RECOVER with walk pointer ptr = 0.
REQ-015 SHALL, in RECOVER, drive recover_valid_o = 1, lane r log = ptr + r, lane r phy = table[ptr + r] (post-commit contents).
REQ-016 SHALL hold recover outputs stable while recover_valid_o & ~recover_ready_i.
REQ-017 SHALL, on recover_valid_o & recover_ready_i, advance ptr by RECOVER_WIDTH modulo NUM_LOG_REGS; on the beat where ptr + RECOVER_WIDTH == NUM_LOG_REGS, go to DONE with ptr = 0.
REQ-018 SHALL, in DONE, assert recover_done_o for exactly one cycle, then return to IDLE.
REQ-019 SHALL ignore recover_req_i in RECOVER and DONE; total beats per walk = NUM_LOG_REGS / RECOVER_WIDTH.
REQ-020 SHALL ignore commit inputs (no write, release_valid_o = 0) whenever commit_ready_o = 0.

Reset
REQ-021 SHALL, while reset = 0, asynchronously set table[i] = i, FSM = IDLE, ptr = 0.
REQ-022 SHALL, while reset = 0, drive commit_ready_o = 0, release_valid_o = 0, recover_valid_o = 0, recover_done_o = 0.
REQ-023 SHALL abandon any walk in progress on reset assertion; no done pulse is produced for it.

Verification (defaults)
REQ-024 Reset low 2 cycles, release, pulse recover_req_i, recover_ready_i = 1 -> 8 beats, beat0 log 0..3 phy 0..3, beat7 log 28..31 phy 28..31, recover_done_o one cycle after beat7, commit_ready_o = 1 next cycle.
REQ-025 Commit slot0 (log 5, phy 40), slot1 (6, 42), slot2 (5, 41), slot3 invalid -> release_valid = 0111, release_phy = {40, 6, 5}; later walk shows table[5] = 41, table[6] = 42.
REQ-026 All four slots log 9, phy 50..53 -> releases 50, 51, 52, 9; table[9] = 53.
REQ-027 Walk with recover_ready_i pattern 1,0,0,1,0,1... -> outputs unchanged during stalls, exactly 8 accepted beats, commit_ready_o = 0 throughout RECOVER and DONE, commits presented then get release_valid_o = 0.
REQ-028 Commit (log 3, phy 60) in same cycle as recover_req_i -> accepted, release phy 3, beat0 lane3 phy = 60.
REQ-029 Assert reset between edges during beat 3 -> outputs go to reset values immediately, no done pulse; post-reset walk returns identity mapping.

Source files
------------

// File: rtl/arch_map_table_n.sv
// Architectural (retirement) map table: multi-port commit with youngest-wins
// update and tag release, plus a beat-by-beat recovery walk to restore the RMT.
module arch_map_table_n #(
  parameter int COMMIT_WIDTH  = 4,
  parameter int NUM_LOG_REGS  = 32,
  parameter int PHY_W         = 7,
  parameter int RECOVER_WIDTH = 4,
  localparam int LOG_W        = $clog2(NUM_LOG_REGS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [COMMIT_WIDTH-1:0]           commit_valid_i,
  input  logic [COMMIT_WIDTH*LOG_W-1:0]     commit_log_i,
  input  logic [COMMIT_WIDTH*PHY_W-1:0]     commit_phy_i,
  output logic                              commit_ready_o,
  output logic [COMMIT_WIDTH-1:0]           release_valid_o,
  output logic [COMMIT_WIDTH*PHY_W-1:0]     release_phy_o,
  input  logic                              recover_req_i,
  output logic                              recover_valid_o,
  input  logic                              recover_ready_i,
  output logic [RECOVER_WIDTH*LOG_W-1:0]    recover_log_o,
  output logic [RECOVER_WIDTH*PHY_W-1:0]    recover_phy_o,
  output logic                              recover_done_o
);

  localparam logic [LOG_W:0]   STEP_X = (LOG_W+1)'(RECOVER_WIDTH);
  localparam logic [LOG_W:0]   WRAP_X = (LOG_W+1)'(NUM_LOG_REGS);
  localparam logic [LOG_W-1:0] STEP   = STEP_X[LOG_W-1:0];

  typedef enum logic [1:0] {IDLE, RECOVER, DONE} fsmState_e;

  fsmState_e         state, stateNext;
  logic [LOG_W-1:0]  walkPtr, walkPtrNext;
  logic [PHY_W-1:0]  mapTable [NUM_LOG_REGS];
  logic              commitReady;
  logic              lastBeat;
  logic [COMMIT_WIDTH-1:0] accept, writeEn;

  // Commits are only taken in IDLE; gating with reset keeps ready low while reset is held.
  assign commitReady     = (state == IDLE) & reset;
  assign commit_ready_o  = commitReady;
  assign release_valid_o = accept;

  always_comb begin
    accept        = commit_valid_i & {COMMIT_WIDTH{commitReady}};
    writeEn       = accept;
    release_phy_o = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      for (int j = k + 1; j < COMMIT_WIDTH; j++) begin
        if (accept[j] && (commit_log_i[j*LOG_W +: LOG_W] == commit_log_i[k*LOG_W +: LOG_W]))
          writeEn[k] = 1'b0;
      end
      // A shadowed slot's own tag is dead on arrival, so it goes straight back.
      release_phy_o[k*PHY_W +: PHY_W] = writeEn[k] ? mapTable[commit_log_i[k*LOG_W +: LOG_W]]
                                                   : commit_phy_i[k*PHY_W +: PHY_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LOG_REGS; i++)
        mapTable[i] <= PHY_W'(i);
    end else begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (writeEn[k])
          mapTable[commit_log_i[k*LOG_W +: LOG_W]] <= commit_phy_i[k*PHY_W +: PHY_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      walkPtr <= '0;
    end else begin
      state   <= stateNext;
      walkPtr <= walkPtrNext;
    end
  end

  assign lastBeat = (({1'b0, walkPtr} + STEP_X) == WRAP_X);

  always_comb begin
    stateNext       = state;
    walkPtrNext     = walkPtr;
    recover_valid_o = 1'b0;
    recover_done_o  = 1'b0;
    case (state)
      IDLE: begin
        if (recover_req_i) begin
          stateNext   = RECOVER;
          walkPtrNext = '0;
        end
      end
      RECOVER: begin
        recover_valid_o = 1'b1;
        if (recover_ready_i) begin
          if (lastBeat) begin
            stateNext   = DONE;
            walkPtrNext = '0;
          end else begin
            walkPtrNext = walkPtr + STEP;
          end
        end
      end
      DONE: begin
        recover_done_o = 1'b1;
        stateNext      = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    recover_log_o = '0;
    recover_phy_o = '0;
    for (int r = 0; r < RECOVER_WIDTH; r++) begin
      recover_log_o[r*LOG_W +: LOG_W] = walkPtr + LOG_W'(r);
      recover_phy_o[r*PHY_W +: PHY_W] = mapTable[walkPtr + LOG_W'(r)];
    end
  end

endmodule

// File: tb/tb_arch_map_table_n.sv
// Scoreboard bench for arch_map_table_n: reference table model, release checks
// per commit cycle, and queued expected beats for every recovery walk.
module tb_arch_map_table_n;
  localparam int CW = 4;
  localparam int NL = 32;
  localparam int PW = 7;
  localparam int RW = 4;
  localparam int LW = 5;
  localparam int BEATS = NL / RW;

  logic              clk;
  logic              reset;
  logic [CW-1:0]     commit_valid_i;
  logic [CW*LW-1:0]  commit_log_i;
  logic [CW*PW-1:0]  commit_phy_i;
  logic              commit_ready_o;
  logic [CW-1:0]     release_valid_o;
  logic [CW*PW-1:0]  release_phy_o;
  logic              recover_req_i;
  logic              recover_valid_o;
  logic              recover_ready_i;
  logic [RW*LW-1:0]  recover_log_o;
  logic [RW*PW-1:0]  recover_phy_o;
  logic              recover_done_o;

  arch_map_table_n #(
    .COMMIT_WIDTH(CW), .NUM_LOG_REGS(NL), .PHY_W(PW), .RECOVER_WIDTH(RW)
  ) dut (
    .clk(clk), .reset(reset),
    .commit_valid_i(commit_valid_i), .commit_log_i(commit_log_i),
    .commit_phy_i(commit_phy_i), .commit_ready_o(commit_ready_o),
    .release_valid_o(release_valid_o), .release_phy_o(release_phy_o),
    .recover_req_i(recover_req_i), .recover_valid_o(recover_valid_o),
    .recover_ready_i(recover_ready_i), .recover_log_o(recover_log_o),
    .recover_phy_o(recover_phy_o), .recover_done_o(recover_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW*LW-1:0] lg;
    logic [RW*PW-1:0] ph;
  } beat_t;

  beat_t          expQ[$];
  logic [PW-1:0]  model [NL];
  bit             readyPat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int             testCount = 0;
  int             failCount = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NL; i++) model[i] = PW'(i);
  endtask

  task automatic pushWalk();
    for (int b = 0; b < BEATS; b++) begin
      beat_t bt;
      for (int r = 0; r < RW; r++) begin
        bt.lg[r*LW +: LW] = LW'(b*RW + r);
        bt.ph[r*PW +: PW] = model[b*RW + r];
      end
      expQ.push_back(bt);
    end
  endtask

  // Entered and left just after a rising edge.
  task automatic doCommit(input logic [CW-1:0] v, input logic [CW*LW-1:0] lg,
                          input logic [CW*PW-1:0] ph, input bit req);
    logic [CW-1:0]    expValid;
    logic [CW*PW-1:0] expPhy, mask;
    commit_valid_i = v;
    commit_log_i   = lg;
    commit_phy_i   = ph;
    recover_req_i  = req;
    @(negedge clk);
    expValid = v;
    expPhy   = '0;
    mask     = '0;
    for (int k = 0; k < CW; k++) begin
      if (expValid[k]) begin
        bit shadow = 1'b0;
        for (int j = k + 1; j < CW; j++)
          if (expValid[j] && lg[j*LW +: LW] == lg[k*LW +: LW]) shadow = 1'b1;
        expPhy[k*PW +: PW] = shadow ? ph[k*PW +: PW] : model[lg[k*LW +: LW]];
        mask[k*PW +: PW]   = '1;
      end
    end
    checkVal("commit_ready", commit_ready_o, 1'b1);
    checkVal("rel_valid", release_valid_o, expValid);
    if (expValid != '0) checkVal("rel_phy", release_phy_o & mask, expPhy);
    for (int k = 0; k < CW; k++)
      if (expValid[k]) model[lg[k*LW +: LW]] = ph[k*PW +: PW];
    if (req) pushWalk();
    @(posedge clk); #1;
    commit_valid_i = '0;
    recover_req_i  = 1'b0;
  endtask

  // Drives a walk already started; mode 1 uses the stall pattern, noise drives commits/reqs.
  task automatic runWalk(input int mode, input bit noise);
    int    beats = 0;
    int    cyc = 0;
    bit    doneSeen = 1'b0;
    bit    stalled = 1'b0;
    beat_t prev = '0;
    beat_t bt;
    while (!doneSeen && cyc < 200) begin
      recover_ready_i = (mode == 0) ? 1'b1 : readyPat[cyc % 6];
      if (noise) begin
        commit_valid_i = CW'($urandom);
        commit_log_i   = (CW*LW)'($urandom);
        commit_phy_i   = (CW*PW)'($urandom);
        recover_req_i  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (recover_valid_o) begin
        checkVal("walk_cready", commit_ready_o, 1'b0);
        if (noise) checkVal("walk_relv", release_valid_o, '0);
        if (stalled) begin
          checkVal("stall_log", recover_log_o, prev.lg);
          checkVal("stall_phy", recover_phy_o, prev.ph);
        end
        if (recover_ready_i) begin
          checkVal("q_nonempty", expQ.size() != 0, 1'b1);
          if (expQ.size() != 0) begin
            bt = expQ.pop_front();
            checkVal($sformatf("beat%0d_log", beats), recover_log_o, bt.lg);
            checkVal($sformatf("beat%0d_phy", beats), recover_phy_o, bt.ph);
          end
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev.lg = recover_log_o;
          prev.ph = recover_phy_o;
        end
      end else if (recover_done_o) begin
        doneSeen = 1'b1;
        checkVal("done_beats", beats, BEATS);
        checkVal("done_cready", commit_ready_o, 1'b0);
        if (noise) checkVal("done_relv", release_valid_o, '0);
      end else begin
        checkVal("walk_active", {recover_valid_o, recover_done_o}, 2'b10);
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!doneSeen) checkVal("done_timeout", doneSeen, 1'b1);
    commit_valid_i  = '0;
    recover_req_i   = 1'b0;
    recover_ready_i = 1'b0;
    @(negedge clk);
    checkVal("idle_cready", commit_ready_o, 1'b1);
    checkVal("done_once", recover_done_o, 1'b0);
    checkVal("q_empty", expQ.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "_cready"}, commit_ready_o, 1'b0);
    checkVal({tag, "_relv"}, release_valid_o, '0);
    checkVal({tag, "_recv"}, recover_valid_o, 1'b0);
    checkVal({tag, "_done"}, recover_done_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", testCount);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    commit_valid_i  = '1;
    commit_log_i    = '0;
    commit_phy_i    = '0;
    recover_req_i   = 1'b0;
    recover_ready_i = 1'b0;
    modelReset();
    repeat (2) begin
      @(negedge clk);
      checkResetOutputs("rst");
    end
    commit_valid_i = '0;
    reset = 1'b1;
    @(posedge clk); #1;

    // Identity walk after reset.
    doCommit('0, '0, '0, 1'b1);
    runWalk(0, 1'b0);

    // Mixed slots with a shadowed older write, then four writes to one register.
    doCommit(4'b0111, {5'd0, 5'd5, 5'd6, 5'd5}, {7'd0, 7'd41, 7'd42, 7'd40}, 1'b0);
    doCommit(4'b1111, {5'd9, 5'd9, 5'd9, 5'd9}, {7'd53, 7'd52, 7'd51, 7'd50}, 1'b0);

    // Stalling walk with commits and requests presented throughout.
    doCommit('0, '0, '0, 1'b1);
    runWalk(1, 1'b1);

    // Commit in the same cycle as the recovery request.
    doCommit(4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {7'd0, 7'd0, 7'd0, 7'd60}, 1'b1);
    runWalk(0, 1'b0);

    for (int n = 0; n < 20; n++)
      doCommit(CW'($urandom), (CW*LW)'($urandom), (CW*PW)'($urandom), 1'b0);
    doCommit('0, '0, '0, 1'b1);
    runWalk(1, 1'b0);

    // Reset between edges while beat 3 is presented.
    begin
      int  beats = 0;
      int  cyc = 0;
      bit  hit = 1'b0;
      beat_t bt;
      doCommit('0, '0, '0, 1'b1);
      recover_ready_i = 1'b1;
      while (!hit && cyc < 50) begin
        @(negedge clk);
        if (recover_valid_o && expQ.size() != 0) begin
          bt = expQ.pop_front();
          checkVal($sformatf("pre_rst_beat%0d_log", beats), recover_log_o, bt.lg);
          if (beats == 3) begin
            #2 reset = 1'b0;
            #1 checkResetOutputs("async_rst");
            hit = 1'b1;
          end
          beats++;
        end
        if (!hit) begin
          @(posedge clk); #1;
        end
        cyc++;
      end
      if (!hit) checkVal("rst_beat3_timeout", hit, 1'b1);
      expQ.delete();
      modelReset();
      repeat (2) begin
        @(negedge clk);
        checkResetOutputs("hold_rst");
      end
      reset = 1'b1;
      recover_ready_i = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      checkVal("post_rst_nodone", recover_done_o, 1'b0);
      @(posedge clk); #1;
      doCommit('0, '0, '0, 1'b1);
      runWalk(0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
